// File: rtl/ahb_rr_master_arbiter.sv
// Round-robin arbiter that serialises single AHB transfers from NUM_REQ
// local requesters onto one master port feeding the AHB-APB bridge.
module ahb_rr_master_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WAIT_MAX = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [31:0]            rdata,
    output logic [1:0]             htrans,
    output logic                   hwrite,
    output logic [31:0]            haddr,
    output logic [31:0]            hwdata,
    output logic                   hready_in,
    input  logic                   hready_out,
    input  logic [1:0]             hresp,
    input  logic [31:0]            hrdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick;
    logic [PW-1:0] owner_nxt;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   wdata_q;
    logic [31:0]   addr_a  [NUM_REQ];
    logic [31:0]   wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_a[g]  = req_addr[32*g +: 32];
        assign wdata_a[g] = req_wdata[32*g +: 32];
    end

    // Nearest set bit at or above p (wrapping) wins; scan downward so
    // the closest candidate is the last to overwrite.
    function automatic logic [PW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [PW-1:0]      p
    );
        logic [PW-1:0] jj;
        rr_pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            jj = PW'((int'(p) + i) % NUM_REQ);
            if (r[jj]) rr_pick = jj;
        end
    endfunction

    assign pick      = rr_pick(req, rr_ptr);
    assign owner_nxt = (owner == PW'(NUM_REQ - 1)) ? '0
                                                   : owner + PW'(1);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            wdata_q   <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            htrans    <= 2'b00;
            hwrite    <= 1'b0;
            haddr     <= '0;
            hwdata    <= '0;
            hready_in <= 1'b0;
        end else begin
            hready_in <= 1'b1;
            done      <= '0;
            err       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        owner   <= pick;
                        grant   <= NUM_REQ'(1) << pick;
                        haddr   <= addr_a[pick];
                        hwrite  <= req_write[pick];
                        wdata_q <= wdata_a[pick];
                        htrans  <= 2'b10;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (hready_out) begin
                        htrans   <= 2'b00;
                        hwdata   <= hwrite ? wdata_q : 32'h0;
                        wait_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hready_out) begin
                        done   <= grant;
                        err    <= |hresp;
                        if (!hwrite) rdata <= hrdata;
                        grant  <= '0;
                        rr_ptr <= owner_nxt;
                        state  <= S_IDLE;
                    end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                        // Slave stalled too long: abort with error.
                        done   <= grant;
                        err    <= 1'b1;
                        grant  <= '0;
                        rr_ptr <= owner_nxt;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_rr_master_arbiter.sv
// Randomised bench for ahb_rr_master_arbiter against a
// transaction-level round-robin reference model.
module tb_ahb_rr_master_arbiter;

    localparam int N    = 4;
    localparam int WMAX = 16;

    logic              hclk = 1'b0;
    logic              hreset;
    logic [N-1:0]      req;
    logic [N-1:0]      req_write;
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_wdata;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic              err;
    logic [31:0]       rdata;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [31:0]       haddr;
    logic [31:0]       hwdata;
    logic              hready_in;
    logic              hready_out;
    logic [1:0]        hresp;
    logic [31:0]       hrdata;

    ahb_rr_master_arbiter #(
        .NUM_REQ (N),
        .WAIT_MAX(WMAX)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hready_out(hready_out),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    always #5 hclk = ~hclk;

    int          nrun;
    int          nfail;
    int          ptr;
    bit [N-1:0]  pend;
    logic [31:0] a_m [N];
    logic [31:0] d_m [N];
    bit          w_m [N];
    logic [31:0] rdata_m;

    task automatic set_req(input int i, input bit wr,
                           input logic [31:0] a, input logic [31:0] d);
        req[i]              = 1'b1;
        req_write[i]        = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        pend[i] = 1'b1;
        w_m[i]  = wr;
        a_m[i]  = a;
        d_m[i]  = d;
    endtask

    task automatic init_inputs();
        req        = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        hready_out = 1'b1;
        hresp      = 2'b00;
        hrdata     = '0;
        pend       = '0;
        ptr        = 0;
        rdata_m    = '0;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        init_inputs();
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    // One complete transfer; winner comes from the model's rotation.
    task automatic run_xfer(input int aw, input int dw,
                            input logic [1:0] resp,
                            input logic [31:0] rd,
                            input bit mutate, output int gw);
        int          w;
        bit          to;
        bit          ew;
        logic [31:0] ea, ed, er;
        logic [N-1:0] oh;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr + i) % N;
            if (w < 0 && pend[j]) w = j;
        end
        gw = w;
        ea = a_m[w];
        ed = d_m[w];
        ew = w_m[w];
        oh = N'(1) << w;
        to = (dw >= WMAX);
        @(negedge hclk);
        nrun++;
        if (grant !== oh || htrans !== 2'b10 || haddr !== ea ||
            hwrite !== ew || hready_in !== 1'b1 || done !== '0) begin
            nfail++;
            $display("FAIL grant: got grant=%b htrans=%0d haddr=%h hwrite=%b hrdy=%b done=%b, want grant=%b htrans=2 haddr=%h hwrite=%b hrdy=1 done=0",
                     grant, htrans, haddr, hwrite, hready_in, done,
                     oh, ea, ew);
        end
        if (mutate) begin
            req_addr[32*w +: 32]  = $urandom;
            req_wdata[32*w +: 32] = $urandom;
            req_write[w] = ~req_write[w];
            if ($urandom_range(1, 0) == 1) begin
                req[w]  = 1'b0;
                pend[w] = 1'b0;
            end
        end
        for (int k = 0; k < aw; k++) begin
            hready_out = 1'b0;
            hresp      = 2'($urandom);
            @(negedge hclk);
            nrun++;
            if (htrans !== 2'b10 || haddr !== ea || grant !== oh) begin
                nfail++;
                $display("FAIL addr_hold: got htrans=%0d haddr=%h grant=%b, want 2 %h %b",
                         htrans, haddr, grant, ea, oh);
            end
        end
        hready_out = 1'b1;
        hresp      = mutate ? 2'($urandom) : 2'b00;
        @(negedge hclk);
        nrun++;
        if (htrans !== 2'b00 || hwdata !== (ew ? ed : 32'h0) ||
            done !== '0) begin
            nfail++;
            $display("FAIL data_entry: got htrans=%0d hwdata=%h done=%b, want 0 %h 0",
                     htrans, hwdata, done, ew ? ed : 32'h0);
        end
        for (int e = 1; e <= WMAX; e++) begin
            if (to || e <= dw) begin
                hready_out = 1'b0;
                hresp      = 2'($urandom);
                hrdata     = $urandom;
            end else begin
                hready_out = 1'b1;
                hresp      = resp;
                hrdata     = rd;
            end
            @(negedge hclk);
            if (to ? (e == WMAX) : (e == dw + 1)) break;
            nrun++;
            if (done !== '0) begin
                nfail++;
                $display("FAIL wait: early done=%b at data cycle %0d", done, e);
            end
        end
        er = (!to && !ew) ? rd : rdata_m;
        nrun++;
        if (done !== oh || err !== (to || resp != 2'b00) ||
            rdata !== er || grant !== '0) begin
            nfail++;
            $display("FAIL done: got done=%b err=%b rdata=%h grant=%b, want done=%b err=%b rdata=%h grant=0",
                     done, err, rdata, grant, oh,
                     to || resp != 2'b00, er);
        end
        rdata_m    = er;
        ptr        = (w + 1) % N;
        pend[w]    = 1'b0;
        req[w]     = 1'b0;
        hready_out = 1'b1;
        hresp      = 2'b00;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        init_inputs();
        #1;
        nrun++;
        if ({grant, done, err, rdata, htrans, hwrite, haddr, hwdata,
             hready_in} !== '0) begin
            nfail++;
            $display("FAIL reset_async: outputs grant=%b htrans=%0d haddr=%h hrdy=%b, want all 0",
                     grant, htrans, haddr, hready_in);
        end
        req = '1;
        repeat (2) @(negedge hclk);
        nrun++;
        if ({grant, done, err, rdata, htrans, hwrite, haddr, hwdata,
             hready_in} !== '0) begin
            nfail++;
            $display("FAIL reset_held: grant=%b htrans=%0d hrdy=%b, want 0",
                     grant, htrans, hready_in);
        end
        req    = '0;
        hreset = 1'b0;
        @(negedge hclk);
        nrun++;
        if (hready_in !== 1'b1 || grant !== '0 || htrans !== 2'b00) begin
            nfail++;
            $display("FAIL reset_release: hrdy=%b grant=%b htrans=%0d, want 1 0 0",
                     hready_in, grant, htrans);
        end
    endtask

    task automatic test_single_write();
        int gw;
        set_req(0, 1'b1, 32'h8842_c0a6, 32'hdead_beef);
        run_xfer(0, 0, 2'b00, 32'h0, 1'b0, gw);
    endtask

    task automatic test_single_read();
        int gw;
        set_req(2, 1'b0, 32'h8400_b866, $urandom);
        run_xfer(0, 0, 2'b00, 32'h1234_5678, 1'b0, gw);
    endtask

    task automatic test_round_robin();
        int gw;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
        for (int n = 0; n < 5; n++) begin
            run_xfer(0, 0, 2'b00, $urandom, 1'b0, gw);
            if (n < 4) set_req(gw, 1'($urandom), $urandom, $urandom);
        end
        while (pend != '0) run_xfer(0, 0, 2'b00, $urandom, 1'b0, gw);
    endtask

    task automatic test_wait_error();
        int gw;
        do_reset();
        set_req(1, 1'b0, $urandom, $urandom);
        run_xfer(0, 3, 2'b01, $urandom, 1'b0, gw);
        set_req(3, 1'b1, $urandom, $urandom);
        run_xfer(2, 1, 2'b00, $urandom, 1'b0, gw);
    endtask

    task automatic test_timeout();
        int gw;
        do_reset();
        set_req(0, 1'b0, $urandom, $urandom);
        set_req(1, 1'b1, $urandom, $urandom);
        run_xfer(0, WMAX, 2'b00, $urandom, 1'b0, gw);
        run_xfer(0, 0, 2'b00, $urandom, 1'b0, gw);
        set_req(2, 1'b0, $urandom, $urandom);
        run_xfer(0, WMAX - 1, 2'b00, 32'hcafe_f00d, 1'b0, gw);
    endtask

    task automatic test_reset_in_addr();
        int gw;
        do_reset();
        set_req(1, 1'b0, $urandom, $urandom);
        run_xfer(0, 0, 2'b00, $urandom, 1'b0, gw);
        set_req(0, 1'b1, $urandom, $urandom);
        set_req(3, 1'b0, $urandom, $urandom);
        @(negedge hclk);
        nrun++;
        if (grant !== 4'b1000 || htrans !== 2'b10) begin
            nfail++;
            $display("FAIL pre_reset_grant: grant=%b htrans=%0d, want 1000 2",
                     grant, htrans);
        end
        #2 hreset = 1'b1;
        #1;
        nrun++;
        if ({grant, done, err, rdata, htrans, hwrite, haddr, hwdata,
             hready_in} !== '0) begin
            nfail++;
            $display("FAIL reset_in_addr: grant=%b done=%b htrans=%0d haddr=%h, want all 0",
                     grant, done, htrans, haddr);
        end
        #1 hreset = 1'b0;
        ptr     = 0;
        rdata_m = '0;
        run_xfer(0, 0, 2'b00, $urandom, 1'b0, gw);
        run_xfer(1, 0, 2'b00, $urandom, 1'b0, gw);
    endtask

    task automatic test_random();
        int gw;
        int aw;
        int dw;
        logic [1:0] resp;
        do_reset();
        repeat (60) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1)
                    set_req(i, 1'($urandom), $urandom, $urandom);
            if (pend == '0)
                set_req($urandom_range(N - 1, 0), 1'($urandom),
                        $urandom, $urandom);
            aw = $urandom_range(2, 0);
            dw = ($urandom_range(7, 0) == 0) ? WMAX : $urandom_range(4, 0);
            resp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1))
                                               : 2'b00;
            run_xfer(aw, dw, resp, $urandom, 1'($urandom), gw);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrun  = 0;
        nfail = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_wait_error();
        test_timeout();
        test_reset_in_addr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
